// File: rtl/bit_cpu.sv
// bit_cpu: 8-bit multicycle core. It has an 8x8 register file, an internal
// instruction memory loaded through the program port, and a request/ready
// data bus for LD/ST.
module bit_cpu #(
  parameter int IMEM_AW  = 5,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               prog_we,
  input  logic [IMEM_AW-1:0] prog_addr,
  input  logic [15:0]        prog_data,
  output logic               pm_req,
  output logic               pm_we,
  output logic [7:0]         pm_addr,
  output logic [7:0]         pm_wdata,
  input  logic [7:0]         pm_rdata,
  input  logic               pm_ready,
  input  logic [2:0]         dbg_sel,
  output logic [7:0]         dbg_data,
  output logic               halted
);

  localparam logic [IMEM_AW-1:0] PC0 = IMEM_AW'(RESET_PC);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [3:0] OP_LI   = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_BEQZ = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  // The low three bits overlap imm8 together with rt and rs[1:0].
  typedef struct packed {
    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [2:0] lo;
  } insn_t;

  logic [2:0]         state;
  logic [IMEM_AW-1:0] pc;
  insn_t              ir;
  logic [7:0][7:0]    rf;
  logic [15:0]        imem [(1<<IMEM_AW)];

  logic [7:0] imm, rs_val, rt_val, rd_val, alu_res;
  logic       alu_wr;

  assign imm      = ir[7:0];
  assign rs_val   = rf[ir.rs];
  assign rt_val   = rf[ir.rt];
  assign rd_val   = rf[ir.rd];
  assign dbg_data = rf[dbg_sel];

  // Program load: only while the core is parked, and never cleared by reset
  always_ff @(posedge clk) begin
    if (prog_we && !run) imem[prog_addr] <= prog_data;
  end

  // ALU result plus a flag telling EXEC whether the opcode writes rd
  always_comb begin
    alu_res = 8'h00;
    alu_wr  = 1'b1;
    case (ir.op)
      OP_LI:   alu_res = imm;
      OP_ADD:  alu_res = rs_val + rt_val;
      OP_SUB:  alu_res = rs_val - rt_val;
      OP_AND:  alu_res = rs_val & rt_val;
      OP_OR:   alu_res = rs_val | rt_val;
      OP_XOR:  alu_res = rs_val ^ rt_val;
      OP_SHL:  alu_res = {rs_val[6:0], 1'b0};
      default: alu_wr  = 1'b0;
    endcase
  end

  // Sequencer: IDLE -> FETCH -> EXEC -> (MEM) -> FETCH, or -> HALT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= PC0;
      ir       <= '0;
      rf       <= '0;
      pm_req   <= 1'b0;
      pm_we    <= 1'b0;
      pm_addr  <= 8'h00;
      pm_wdata <= 8'h00;
      halted   <= 1'b0;
    end else if (!run) begin
      // Dropping run abandons any bus access in flight without a write-back
      state  <= S_IDLE;
      pc     <= PC0;
      halted <= 1'b0;
      pm_req <= 1'b0;
      pm_we  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          ir    <= imem[pc];
          pc    <= pc + IMEM_AW'(1);
          state <= S_FETCH + 3'd1;
        end
        S_EXEC: begin
          state <= S_FETCH;
          if (alu_wr) rf[ir.rd] <= alu_res;
          case (ir.op)
            OP_JMP:  pc <= imm[IMEM_AW-1:0];
            OP_BEQZ: if (rd_val == 8'h00) pc <= imm[IMEM_AW-1:0];
            OP_LD, OP_ST: begin
              pm_req   <= 1'b1;
              pm_we    <= (ir.op == OP_ST);
              pm_addr  <= rs_val;
              pm_wdata <= rt_val;
              state    <= S_MEM;
            end
            OP_HALT: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          // pm_* stay registered and stable until the target completes
          if (pm_ready) begin
            pm_req <= 1'b0;
            pm_we  <= 1'b0;
            if (ir.op == OP_LD) rf[ir.rd] <= pm_rdata;
            state  <= S_FETCH;
          end
        end
        S_HALT: halted <= 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_cpu.sv
// tb_bit_cpu: directed programs for bit_cpu. An instruction-level model gives
// the final registers, the ordered bus transactions and the total cycle count.
// A bus responder checks every cycle that pm_req is high against the model.
module tb_bit_cpu;

  logic        clk = 1'b0, rst = 1'b1, run = 1'b0, prog_we = 1'b0;
  logic [4:0]  prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic        pm_req, pm_we, halted;
  logic [7:0]  pm_addr, pm_wdata, dbg_data;
  logic [7:0]  pm_rdata = '0;
  logic        pm_ready = 1'b0;
  logic [2:0]  dbg_sel = '0;

  int checks = 0, errors = 0;

  typedef struct { int we; int addr; int wdata; } txn_t;
  txn_t        exp_q[$];
  int          exp_regs[8];
  int          exp_cycles;
  int          waits[16];
  logic [15:0] pmem[32];
  logic [7:0]  bmem[256];
  int          tidx;
  bit          chk_len = 1'b1, stray_ready = 1'b0;

  bit_cpu #(.IMEM_AW(5), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .pm_req(pm_req), .pm_we(pm_we), .pm_addr(pm_addr),
    .pm_wdata(pm_wdata), .pm_rdata(pm_rdata), .pm_ready(pm_ready),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rrr(input int op, input int rd, input int rs, input int rt);
    return {4'(op), 3'(rd), 3'(rs), 3'(rt), 3'b000};
  endfunction

  function automatic logic [15:0] ri(input int op, input int rd, input int imm);
    return {4'(op), 3'(rd), 1'b0, 8'(imm)};
  endfunction

  // Instruction-level model: each instruction costs 2 cycles, plus wait+1 for a bus op
  task automatic build_model();
    int r[8]; int m[256]; int pc, k, op, rd, rs, rt, imm, a;
    bit done;
    logic [15:0] ir;
    for (int i = 0; i < 8; i++) r[i] = 0;
    for (int i = 0; i < 256; i++) m[i] = int'(bmem[i]);
    exp_q.delete();
    pc = 0; k = 0; done = 1'b0; exp_cycles = 1;
    for (int step = 0; step < 1000 && !done; step++) begin
      ir = pmem[pc];
      pc = (pc + 1) % 32;
      op = int'(ir[15:12]); rd = int'(ir[11:9]); rs = int'(ir[8:6]);
      rt = int'(ir[5:3]);   imm = int'(ir[7:0]);
      exp_cycles += 2;
      case (op)
        1: r[rd] = imm;
        2: r[rd] = (r[rs] + r[rt]) % 256;
        3: r[rd] = (r[rs] - r[rt] + 256) % 256;
        4: r[rd] = r[rs] & r[rt];
        5: r[rd] = r[rs] | r[rt];
        6: r[rd] = r[rs] ^ r[rt];
        7: r[rd] = (r[rs] * 2) % 256;
        8: begin
          a = r[rs];
          exp_q.push_back('{0, a, r[rt]});
          exp_cycles += waits[k] + 1; k++;
          r[rd] = m[a];
        end
        9: begin
          a = r[rs];
          exp_q.push_back('{1, a, r[rt]});
          exp_cycles += waits[k] + 1; k++;
          m[a] = r[rt];
        end
        10: pc = imm % 32;
        11: if (r[rd] == 0) pc = imm % 32;
        15: done = 1'b1;
        default: ;
      endcase
    end
    for (int i = 0; i < 8; i++) exp_regs[i] = r[i];
  endtask

  // Bus target and per-cycle bus checker
  initial begin
    int wcnt, cw;
    bit in_txn;
    for (int i = 0; i < 256; i++) bmem[i] = 8'((i * 7 + 3) % 256);
    bmem[8'h20] = 8'hA5;
    tidx = 0; wcnt = 0; in_txn = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !run) begin
        tidx = 0; wcnt = 0; in_txn = 1'b0; pm_ready = 1'b0;
      end else if (pm_req) begin
        if (tidx < exp_q.size()) begin
          chk($sformatf("bus%0d we", tidx),    32'(pm_we),    32'(exp_q[tidx].we));
          chk($sformatf("bus%0d addr", tidx),  32'(pm_addr),  32'(exp_q[tidx].addr));
          chk($sformatf("bus%0d wdata", tidx), 32'(pm_wdata), 32'(exp_q[tidx].wdata));
        end else begin
          chk("bus extra req", 32'(tidx), 32'(exp_q.size()));
        end
        cw = (tidx < 16) ? waits[tidx] : 0;
        pm_rdata = bmem[pm_addr];
        if (wcnt >= cw) begin
          pm_ready = 1'b1;
          if (pm_we) bmem[pm_addr] = pm_wdata;
        end else begin
          pm_ready = 1'b0;
        end
        wcnt++; in_txn = 1'b1;
      end else begin
        if (in_txn) begin
          if (chk_len) chk($sformatf("bus%0d req cycles", tidx), 32'(wcnt), 32'(waits[tidx] + 1));
          tidx++; in_txn = 1'b0;
        end
        wcnt = 0;
        pm_ready = stray_ready;
      end
    end
  end

  task automatic load_prog();
    @(negedge clk);
    run = 1'b0;
    for (int i = 0; i < 32; i++) begin
      prog_we = 1'b1; prog_addr = 5'(i); prog_data = pmem[i];
      @(negedge clk);
    end
    prog_we = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) pmem[i] = 16'h0000;
  endtask

  task automatic lit(input string name, input int idx, input int val);
    dbg_sel = 3'(idx);
    #1 chk(name, 32'(dbg_data), 32'(val));
  endtask

  // Reset, run to HALT, then compare cycles, registers and bus completion with the model
  task automatic run_prog(input string tag, input bit inj, input int inj_addr,
                          input logic [15:0] inj_data, output int cyc);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    build_model();
    @(negedge clk); run = 1'b1;
    cyc = 0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      cyc++;
      #1;
      if (inj && cyc < 4) begin
        prog_we = 1'b1; prog_addr = 5'(inj_addr); prog_data = inj_data;
      end else begin
        prog_we = 1'b0;
      end
      if (halted) break;
    end
    prog_we = 1'b0;
    chk({tag, " halted"}, 32'(halted), 32'd1);
    chk({tag, " cycles"}, 32'(cyc), 32'(exp_cycles));
    chk({tag, " bus txns"}, 32'(tidx), 32'(exp_q.size()));
    for (int i = 0; i < 8; i++) lit($sformatf("%s r%0d", tag, i), i, exp_regs[i]);
    @(negedge clk); run = 1'b0;
    @(negedge clk);
    chk({tag, " halted cleared"}, 32'(halted), 32'd0);
    chk({tag, " req idle"}, 32'(pm_req), 32'd0);
  endtask

  task automatic prog1();
    clear_prog();
    pmem[0] = ri(1, 0, 8'h1F);
    pmem[1] = ri(1, 1, 8'h01);
    pmem[2] = rrr(3, 2, 0, 1);
    pmem[3] = rrr(5, 3, 1, 1);
    pmem[4] = rrr(4, 4, 1, 0);
    pmem[5] = ri(1, 5, 8'h1F);
    pmem[6] = rrr(6, 6, 5, 2);
    pmem[7] = rrr(9, 0, 1, 6);
    pmem[8] = 16'hF000;
  endtask

  task automatic lit_prog1(input string tag);
    lit({tag, " lit r0"}, 0, 8'h1F); lit({tag, " lit r1"}, 1, 8'h01);
    lit({tag, " lit r2"}, 2, 8'h1E); lit({tag, " lit r3"}, 3, 8'h01);
    lit({tag, " lit r4"}, 4, 8'h01); lit({tag, " lit r5"}, 5, 8'h1F);
    lit({tag, " lit r6"}, 6, 8'h01);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 16; i++) waits[i] = 0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst pm_req", 32'(pm_req), 32'd0);
    chk("rst pm_we", 32'(pm_we), 32'd0);
    chk("rst pm_addr", 32'(pm_addr), 32'd0);
    chk("rst pm_wdata", 32'(pm_wdata), 32'd0);
    chk("rst halted", 32'(halted), 32'd0);
    for (int i = 0; i < 8; i++) lit($sformatf("rst r%0d", i), i, 0);
    @(negedge clk); rst = 1'b0;

    // ALU basics, single-cycle store
    prog1(); load_prog();
    run_prog("alu", 1'b0, 0, 16'h0, cyc);
    lit_prog1("alu");
    chk("alu lit cycles", 32'(cyc), 32'd20);

    // Store with 3 wait cycles, load ready at once, stray ready ignored
    clear_prog();
    pmem[0] = ri(1, 1, 8'h10);
    pmem[1] = ri(1, 2, 8'h5A);
    pmem[2] = ri(1, 4, 8'h20);
    pmem[3] = rrr(9, 0, 1, 2);
    pmem[4] = rrr(8, 3, 4, 0);
    pmem[5] = 16'hF000;
    load_prog();
    waits[0] = 3; waits[1] = 0; stray_ready = 1'b1;
    run_prog("mem", 1'b0, 0, 16'h0, cyc);
    stray_ready = 1'b0; waits[0] = 0;
    lit("mem lit r3", 3, 8'hA5);
    chk("mem lit cycles", 32'(cyc), 32'd18);
    chk("mem lit stored", 32'(bmem[8'h10]), 32'h5A);

    // Modulo arithmetic; program writes while running must be ignored
    clear_prog();
    pmem[0] = ri(1, 0, 8'hFF);
    pmem[1] = ri(1, 1, 8'h01);
    pmem[2] = rrr(2, 2, 0, 1);
    pmem[3] = rrr(3, 3, 2, 1);
    pmem[4] = ri(1, 4, 8'h81);
    pmem[5] = rrr(7, 5, 4, 0);
    pmem[6] = 16'hF000;
    load_prog();
    run_prog("wrap", 1'b1, 5, ri(1, 5, 8'hEE), cyc);
    lit("wrap lit r2", 2, 8'h00);
    lit("wrap lit r3", 3, 8'hFF);
    lit("wrap lit r5", 5, 8'h02);
    chk("wrap lit cycles", 32'(cyc), 32'd15);

    // Fall-through BEQZ, 3-iteration countdown, PC wrap 31 -> 0
    clear_prog();
    pmem[0]  = ri(11, 5, 2);
    pmem[1]  = ri(10, 0, 20);
    pmem[2]  = ri(1, 0, 3);
    pmem[3]  = ri(1, 1, 1);
    pmem[4]  = ri(11, 1, 31);
    pmem[5]  = ri(1, 3, 8'h55);
    pmem[6]  = rrr(3, 0, 0, 1);
    pmem[7]  = rrr(2, 2, 2, 1);
    pmem[8]  = ri(11, 0, 10);
    pmem[9]  = ri(10, 0, 6);
    pmem[10] = ri(10, 0, 30);
    pmem[20] = ri(1, 4, 8'h44);
    pmem[21] = 16'hF000;
    pmem[30] = ri(1, 5, 8'h66);
    pmem[31] = ri(1, 6, 8'h99);
    load_prog();
    run_prog("loop", 1'b0, 0, 16'h0, cyc);
    lit("loop lit r0", 0, 0);
    lit("loop lit r2", 2, 3);
    lit("loop lit r3", 3, 8'h55);
    lit("loop lit r4", 4, 8'h44);
    lit("loop lit r6", 6, 8'h99);

    // JMP located at address 31
    clear_prog();
    pmem[0]  = ri(10, 0, 31);
    pmem[1]  = ri(1, 7, 8'hEE);
    pmem[2]  = 16'hF000;
    pmem[3]  = ri(1, 7, 8'hAB);
    pmem[4]  = 16'hF000;
    pmem[31] = ri(10, 0, 3);
    load_prog();
    run_prog("jmp31", 1'b0, 0, 16'h0, cyc);
    lit("jmp31 lit r7", 7, 8'hAB);

    // Reset in the middle of a stalled store, then rerun the intact program
    prog1(); load_prog();
    waits[0] = 1000; chk_len = 1'b0;
    build_model();
    @(negedge clk); run = 1'b1;
    cyc = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); cyc++;
      #1;
      if (pm_req) break;
    end
    chk("abort req seen", 32'(pm_req), 32'd1);
    chk("abort req cycle", 32'(cyc), 32'd17);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort pm_req", 32'(pm_req), 32'd0);
    chk("abort halted", 32'(halted), 32'd0);
    for (int i = 0; i < 8; i++) lit($sformatf("abort r%0d", i), i, 0);
    @(negedge clk); run = 1'b0; rst = 1'b0;
    waits[0] = 0; chk_len = 1'b1;
    run_prog("rerun", 1'b0, 0, 16'h0, cyc);
    lit_prog1("rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_cpu.md
Name: bit_cpu

Overview:
- Small 8-bit multicycle processor core with an 8x8 register file and a 32x16 internal instruction memory, loaded through a program port.
- Data loads and stores go out on the Processor_Bus processor-side port group (pm_*), a request/ready handshake toward the AMBA-APB/I2C subsystem.
- A debug read port exposes any register so a bench can dump and compare results.

Parameters:
- IMEM_AW, 5, instruction memory address width (depth 2**IMEM_AW; PC width).
- RESET_PC, 0, PC value after reset and while run is low.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- run  in  1  1 = execute; 0 = hold in IDLE with PC = RESET_PC.
- prog_we  in  1  instruction memory write strobe, honoured only while run = 0.
- prog_addr  in  IMEM_AW  instruction memory write address.
- prog_data  in  16  instruction word.
- pm_req  out  1  bus request (Processor_Bus processor modport).
- pm_we  out  1  1 = write, 0 = read; valid while pm_req = 1.
- pm_addr  out  8  bus address.
- pm_wdata  out  8  bus write data.
- pm_rdata  in  8  bus read data, sampled when pm_ready = 1.
- pm_ready  in  1  bus completion.
- dbg_sel  in  3  register select.
- dbg_data  out  8  combinational value of register dbg_sel.
- halted  out  1  1 after a HALT executes.

Behaviour:
- Async reset:
  - All registers r0..r7 = 0x00, PC = RESET_PC, state = IDLE.
  - pm_req = 0, pm_we = 0, pm_addr = 0, pm_wdata = 0, halted = 0.
  - Instruction memory contents are not cleared.
- Instruction format: op[15:12], rd[11:9], rs[8:6], rt[5:3], imm8[7:0].
- Opcodes:
  - 0 NOP.
  - 1 LI: rd = imm8.
  - 2 ADD: rd = rs + rt.
  - 3 SUB: rd = rs - rt.
  - 4 AND, 5 OR, 6 XOR: rd = rs op rt.
  - 7 SHL: rd = rs << 1.
  - 8 LD: rd = bus[rs].
  - 9 ST: bus[rs] = rt.
  - A JMP: PC = imm8[IMEM_AW-1:0].
  - B BEQZ: if rd == 0, PC = imm8[IMEM_AW-1:0].
  - F HALT.
  - C, D, E execute as NOP.
- Arithmetic: 8-bit modulo 2^8, no flags; SHL discards bit 7.
- State machine:
  - IDLE: taken when run = 0 from any state; PC forced to RESET_PC; halted cleared. When run = 1, go to FETCH.
  - FETCH (1 cycle): IR <= imem[PC]; PC <= PC+1 (wraps 31 -> 0); go to EXEC.
  - EXEC (1 cycle):
    - ALU/LI: write rd; go to FETCH.
    - JMP/BEQZ: update PC; go to FETCH.
    - LD/ST: drive pm_req = 1, pm_addr = rs, pm_we = (op == ST), pm_wdata = rt; go to MEM.
    - HALT: go to HALT.
  - MEM: hold pm_* stable until pm_ready = 1. On that cycle, LD writes pm_rdata to rd; pm_req drops next cycle; go to FETCH. pm_ready already high in the first MEM cycle completes the access in one cycle.
  - HALT: halted = 1, no bus activity; stays until run = 0 or rst.
- Latency: 2 cycles per non-memory instruction; 2 + (cycles in MEM, minimum 1) per LD/ST.
- Register write timing: writes take effect on the clock edge ending EXEC (or MEM for LD). dbg_data reflects the write on the following cycle.
- Reset or run = 0 during MEM abandons the access: pm_req = 0 immediately (reset) or on the next edge (run = 0). No register write occurs.
- pm_ready while pm_req = 0 is ignored.
- prog_we while run = 1 is ignored.

Test Plan:
- Load the program "LI r0,0x1F; LI r1,0x01; SUB r2,r0,r1; OR r3,r1,r1; AND r4,r1,r0; LI r5,0x1F; XOR r6,r5,r2; ... HALT", run, wait for halted. Read dbg r0..r6 -> 0x1F, 0x01, 0x1E, 0x01, 0x01, 0x1F, 0x01.
- ST with r1 = 0x10, r2 = 0x5A; hold pm_ready low 3 cycles -> pm_req = 1, pm_we = 1, pm_addr = 0x10, pm_wdata = 0x5A, stable for all 4 cycles; pm_req = 0 after ready.
- LD r3,[r1] with pm_rdata = 0xA5 and ready in the first MEM cycle -> r3 = 0xA5, instruction completes in 3 cycles.
- Arithmetic wrap: LI r0,0xFF; LI r1,0x01; ADD r2,r0,r1 -> r2 = 0x00. SUB r3,r2,r1 -> 0xFF. SHL of 0x81 -> 0x02.
- Branch/loop: BEQZ on nonzero falls through; a countdown loop from 3 exits after 3 iterations. JMP from address 31 and PC wrap 31 -> 0 both verified.
- Assert rst mid-MEM -> pm_req = 0 immediately, all registers 0x00, halted = 0. Program still intact; rerun reproduces the first scenario's results.
